// File: rtl/flag_bank_arbiter.sv
// Round-robin arbiter that serialises per-requester set/reset commands into a
// shared bank of SR flags, one command per IDLE -> EXEC -> ACK transaction.
module flag_bank_arbiter #(
  parameter int NREQ  = 4,
  parameter int NFLAG = 8,
  parameter int IDXW  = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [NREQ-1:0]      cmd_s,
  input  logic [NREQ-1:0]      cmd_r,
  input  logic [NREQ*IDXW-1:0] cmd_idx,
  input  logic                 clr_all,
  output logic [NREQ-1:0]      ack,
  output logic [NREQ-1:0]      err,
  output logic [NFLAG-1:0]     flags,
  output logic                 busy
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

  // Handshake: a requester raises req with its command and holds both until
  // ack pulses; it drops req on the edge that ends the ack cycle. A req still
  // high once the FSM is back in IDLE counts as a fresh request.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    ACK  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [IDW-1:0]   rr_ptr;
  logic [IDW-1:0]   win_c;
  logic [IDW-1:0]   win_id;
  logic             found;
  int               scan_j;
  logic             lat_s;
  logic             lat_r;
  logic [IDXW-1:0]  lat_idx;
  logic             illegal;
  logic [NFLAG-1:0] flags_wr;
  logic [NREQ-1:0]  win_onehot;

  // First requester at or after rr_ptr, wrapping past NREQ-1.
  always_comb begin
    win_c  = rr_ptr;
    found  = 1'b0;
    scan_j = 0;
    for (int k = 0; k < NREQ; k++) begin
      scan_j = (int'(rr_ptr) + k) % NREQ;
      if (!found && req[scan_j]) begin
        found = 1'b1;
        win_c = IDW'(scan_j);
      end
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (|req) state_nx = EXEC;
      EXEC:    state_nx = ACK;
      ACK:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  assign busy = (state != IDLE);

  // An out-of-range index never matches any flag, so it falls through as a hold.
  always_comb begin
    illegal  = (lat_s & lat_r) | (int'(lat_idx) >= NFLAG);
    flags_wr = flags;
    for (int k = 0; k < NFLAG; k++) begin
      if (int'(lat_idx) == k) begin
        if (lat_s && !lat_r)      flags_wr[k] = 1'b1;
        else if (!lat_s && lat_r) flags_wr[k] = 1'b0;
      end
    end
  end

  always_comb begin
    win_onehot = '0;
    for (int k = 0; k < NREQ; k++) begin
      win_onehot[k] = (int'(win_id) == k);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr_ptr  <= '0;
      win_id  <= '0;
      lat_s   <= 1'b0;
      lat_r   <= 1'b0;
      lat_idx <= '0;
      ack     <= '0;
      err     <= '0;
    end else begin
      ack <= '0;
      err <= '0;
      case (state)
        IDLE: begin
          if (|req) begin
            win_id  <= win_c;
            lat_s   <= cmd_s[win_c];
            lat_r   <= cmd_r[win_c];
            lat_idx <= cmd_idx[int'(win_c)*IDXW +: IDXW];
          end
        end
        EXEC: begin
          ack <= win_onehot;
          err <= illegal ? win_onehot : '0;
        end
        ACK: begin
          rr_ptr <= (int'(win_id) == NREQ - 1) ? '0 : win_id + IDW'(1);
        end
        default: ;
      endcase
    end
  end

  // clr_all wins over the EXEC write but leaves the transaction itself alone.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)              flags <= '0;
    else if (clr_all)        flags <= '0;
    else if (state == EXEC)  flags <= flags_wr;
  end

endmodule

// File: tb/tb_flag_bank_arbiter.sv
// Bench for flag_bank_arbiter: vector table, hand-written corner sequences and
// a randomized run checked against a queue-free arbitration/flag model.
module tb_flag_bank_arbiter;

  localparam int NREQ  = 4;
  localparam int NFLAG = 8;
  localparam int IDXW  = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  req;
  logic [3:0]  cmd_s;
  logic [3:0]  cmd_r;
  logic [11:0] cmd_idx;
  logic        clr_all;
  logic [3:0]  ack;
  logic [3:0]  err;
  logic [7:0]  flags;
  logic        busy;

  logic [3:0]  req6;
  logic [3:0]  s6;
  logic [3:0]  r6;
  logic [11:0] idx6;
  logic        clr6;
  logic [3:0]  ack6;
  logic [3:0]  err6;
  logic [5:0]  flags6;
  logic        busy6;

  int checks = 0;
  int errors = 0;

  logic [7:0] m_flags;
  int         m_rr;

  typedef struct {
    int         who;
    bit         s;
    bit         r;
    int         idx;
    logic [3:0] exp_ack;
    logic [3:0] exp_err;
    logic [7:0] exp_flags;
  } vec_t;

  vec_t tbl[8];

  flag_bank_arbiter #(.NREQ(NREQ), .NFLAG(NFLAG), .IDXW(IDXW)) dut (
    .clk(clk), .reset(reset), .req(req), .cmd_s(cmd_s), .cmd_r(cmd_r),
    .cmd_idx(cmd_idx), .clr_all(clr_all), .ack(ack), .err(err),
    .flags(flags), .busy(busy)
  );

  flag_bank_arbiter #(.NREQ(4), .NFLAG(6), .IDXW(3)) dut6 (
    .clk(clk), .reset(reset), .req(req6), .cmd_s(s6), .cmd_r(r6),
    .cmd_idx(idx6), .clr_all(clr6), .ack(ack6), .err(err6),
    .flags(flags6), .busy(busy6)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_cmd(input int who, input bit s, input bit r, input int idx);
    req[who]                 = 1'b1;
    cmd_s[who]               = s;
    cmd_r[who]               = r;
    cmd_idx[who*IDXW +: IDXW] = IDXW'(idx);
  endtask

  task automatic do_reset();
    @(negedge clk);
    req   = '0;
    reset = 1'b0;
    #1;
    check("rst_flags", 32'(flags), 32'h0);
    check("rst_ack",   32'(ack),   32'h0);
    check("rst_err",   32'(err),   32'h0);
    check("rst_busy",  32'(busy),  32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Called with the DUT in IDLE and requests presented; waits (bounded) for the
  // ack, checks the whole result, then drops the winner's req.
  task automatic expect_txn(input logic [3:0] exp_ack, input logic [3:0] exp_err,
                            input logic [7:0] exp_flags, input bit scramble,
                            input string name);
    int n = 0;
    bit got = 1'b0;
    while (!got && n < 6) begin
      @(posedge clk);
      #1;
      n++;
      if (ack != 4'b0) got = 1'b1;
      else begin
        check({name, "_busy_exec"}, 32'(busy), 32'h1);
        if (scramble && n == 1) begin
          cmd_s   = 4'($urandom);
          cmd_r   = 4'($urandom);
          cmd_idx = 12'($urandom);
        end
      end
    end
    check({name, "_latency"}, 32'(n),     32'd2);
    check({name, "_ack"},     32'(ack),   32'(exp_ack));
    check({name, "_err"},     32'(err),   32'(exp_err));
    check({name, "_flags"},   32'(flags), 32'(exp_flags));
    check({name, "_busy_ack"}, 32'(busy), 32'h1);
    @(posedge clk);
    #1;
    req = req & ~exp_ack;
    check({name, "_ack_off"},  32'(ack),  32'h0);
    check({name, "_err_off"},  32'(err),  32'h0);
    check({name, "_busy_off"}, 32'(busy), 32'h0);
  endtask

  initial begin
    logic [7:0] ef;
    int w;
    logic s_b, r_b;
    int ix;
    logic [3:0] ea;

    tbl[0] = '{0, 1, 0, 5, 4'b0001, 4'b0000, 8'h20};
    tbl[1] = '{1, 1, 0, 0, 4'b0010, 4'b0000, 8'h21};
    tbl[2] = '{2, 0, 1, 5, 4'b0100, 4'b0000, 8'h01};
    tbl[3] = '{3, 0, 0, 0, 4'b1000, 4'b0000, 8'h01};
    tbl[4] = '{3, 1, 1, 0, 4'b1000, 4'b1000, 8'h01};
    tbl[5] = '{2, 1, 0, 7, 4'b0100, 4'b0000, 8'h81};
    tbl[6] = '{1, 0, 1, 0, 4'b0010, 4'b0000, 8'h80};
    tbl[7] = '{0, 1, 0, 3, 4'b0001, 4'b0000, 8'h88};

    req = '0; cmd_s = '0; cmd_r = '0; cmd_idx = '0; clr_all = 1'b0;
    req6 = '0; s6 = '0; r6 = '0; idx6 = '0; clr6 = 1'b0;
    #1 reset = 1'b0;
    do_reset();

    // table vectors, single requester each, commands scrambled after capture
    for (int t = 0; t < 8; t++) begin
      set_cmd(tbl[t].who, tbl[t].s, tbl[t].r, tbl[t].idx);
      expect_txn(tbl[t].exp_ack, tbl[t].exp_err, tbl[t].exp_flags, 1'b1,
                 $sformatf("vec%0d", t));
    end

    // all four requesting: round-robin order with an immediate re-request
    do_reset();
    for (int i = 0; i < 4; i++) set_cmd(i, 1'b1, 1'b0, i + 4);
    expect_txn(4'b0001, 4'b0, 8'h10, 1'b0, "rr0");
    set_cmd(0, 1'b1, 1'b0, 0);
    expect_txn(4'b0010, 4'b0, 8'h30, 1'b0, "rr1");
    expect_txn(4'b0100, 4'b0, 8'h70, 1'b0, "rr2");
    expect_txn(4'b1000, 4'b0, 8'hF0, 1'b0, "rr3");
    expect_txn(4'b0001, 4'b0, 8'hF1, 1'b0, "rr0_again");

    // fill to 0xFF, then an illegal s=r=1 command from requester 2
    ef = 8'hF1;
    for (int i = 1; i < 4; i++) begin
      set_cmd(0, 1'b1, 1'b0, i);
      ef[i] = 1'b1;
      expect_txn(4'b0001, 4'b0, ef, 1'b0, $sformatf("fill%0d", i));
    end
    set_cmd(2, 1'b1, 1'b1, 3);
    expect_txn(4'b0100, 4'b0100, 8'hFF, 1'b0, "both_sr");

    // clr_all coinciding with the EXEC write
    set_cmd(0, 1'b1, 1'b0, 1);
    @(posedge clk);
    #1;
    check("clr_exec_busy", 32'(busy), 32'h1);
    clr_all = 1'b1;
    @(posedge clk);
    #1;
    clr_all = 1'b0;
    check("clr_exec_ack",   32'(ack),   32'h1);
    check("clr_exec_err",   32'(err),   32'h0);
    check("clr_exec_flags", 32'(flags), 32'h0);
    @(posedge clk);
    #1;
    req[0] = 1'b0;
    check("clr_exec_idle",  32'(busy),  32'h0);
    check("clr_exec_hold",  32'(flags), 32'h0);

    // reset during EXEC discards the command and restarts rr at 0
    set_cmd(2, 1'b1, 1'b0, 0);
    expect_txn(4'b0100, 4'b0, 8'h01, 1'b0, "pre_rst");
    set_cmd(3, 1'b1, 1'b0, 7);
    @(posedge clk);
    #1;
    check("midrst_busy", 32'(busy), 32'h1);
    reset = 1'b0;
    #1;
    check("midrst_flags", 32'(flags), 32'h0);
    check("midrst_ack",   32'(ack),   32'h0);
    check("midrst_busy0", 32'(busy),  32'h0);
    @(posedge clk);
    #1;
    check("midrst_ack2",  32'(ack),   32'h0);
    @(negedge clk);
    reset = 1'b1;
    set_cmd(1, 1'b1, 1'b0, 2);
    expect_txn(4'b0010, 4'b0, 8'h04, 1'b0, "post_rst1");
    expect_txn(4'b1000, 4'b0, 8'h84, 1'b0, "post_rst3");

    // clr_all in IDLE
    @(negedge clk);
    clr_all = 1'b1;
    @(posedge clk);
    #1;
    clr_all = 1'b0;
    check("clr_idle_flags", 32'(flags), 32'h0);
    check("clr_idle_busy",  32'(busy),  32'h0);

    // NFLAG=6 instance: a legal set, then index 7 out of range
    req6 = 4'b1000; s6 = 4'b1000; r6 = '0; idx6 = '0; idx6[9 +: 3] = 3'd5;
    repeat (2) @(posedge clk);
    #1;
    check("n6_ack",   32'(ack6),   32'h8);
    check("n6_err",   32'(err6),   32'h0);
    check("n6_flags", 32'(flags6), 32'h20);
    @(posedge clk);
    #1;
    idx6[9 +: 3] = 3'd7;
    check("n6_idle", 32'(busy6), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    check("n6_oor_ack",   32'(ack6),   32'h8);
    check("n6_oor_err",   32'(err6),   32'h8);
    check("n6_oor_flags", 32'(flags6), 32'h20);
    @(posedge clk);
    #1;
    req6 = '0;
    check("n6_oor_off", 32'(err6), 32'h0);

    // randomized traffic against the reference model
    m_flags = 8'h00;
    m_rr    = 0;
    for (int it = 0; it < 40; it++) begin
      for (int i = 0; i < 4; i++) begin
        if (!req[i] && $urandom_range(0, 1) == 1)
          set_cmd(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  int'($urandom_range(0, 7)));
      end
      if (req == 4'b0)
        set_cmd(int'($urandom_range(0, 3)), 1'b1, 1'b0, int'($urandom_range(0, 7)));
      w = -1;
      for (int k = 0; k < 4; k++) begin
        if (w < 0 && req[(m_rr + k) % 4]) w = (m_rr + k) % 4;
      end
      s_b = cmd_s[w];
      r_b = cmd_r[w];
      ix  = int'(cmd_idx[w*IDXW +: IDXW]);
      ea  = 4'b0001 << w;
      if (s_b && !r_b) m_flags[ix] = 1'b1;
      if (r_b && !s_b) m_flags[ix] = 1'b0;
      m_rr = (w + 1) % 4;
      expect_txn(ea, (s_b && r_b) ? ea : 4'b0, m_flags, 1'b0, $sformatf("rand%0d", it));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
